// File: rtl/spike_pkg.sv
// spike_pkg: address type and timestep defaults shared by dispatcher, MAC and router.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spike_pkg;
  localparam int SPIKE_ADDR_W = 12;
  localparam int SPIKE_TIMESTEP_CYCLES = 4;
  localparam logic [SPIKE_ADDR_W-1:0] SPIKE_IDLE_ADDR = 12'hFFF;

  typedef logic [SPIKE_ADDR_W-1:0] spike_addr_t;
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO; a wrap bit on each pointer separates full from empty.
// Latency: an entry pushed at an edge is at head_dat from the following cycle.
// Backpressure: push is ignored when full and pop when empty; callers gate on full/empty.
module spike_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                  CLK_Mac,
  input  logic                  RESET_Mac,
  input  logic                  push,
  input  logic [W-1:0]          push_dat,
  input  logic                  pop,
  output logic [W-1:0]          head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge CLK_Mac) begin
    if (RESET_Mac) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_Mac) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/spike_dispatcher.sv
// spike_dispatcher: buffers router spikes, presents one per clock to the MAC, emits the timestep clear (stats ports under SPIKE_DISPATCH_STATS_EN).
// Latency: spike accepted at edge E is presented in the cycle after edge E+1 unless that cycle is a clear cycle.
// Backpressure: in_ready drops on FIFO full (no same-cycle pop bypass) and while RESET_Mac is high.
module spike_dispatcher
  import spike_pkg::*;
#(
  parameter int ADDR_W          = SPIKE_ADDR_W,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMESTEP_CYCLES = SPIKE_TIMESTEP_CYCLES,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(SPIKE_IDLE_ADDR)
) (
  input  logic                         CLK_Mac,
  input  logic                         RESET_Mac,
  input  logic                         in_valid,
  input  logic [ADDR_W-1:0]            in_addr,
  output logic                         in_ready,
  output logic [ADDR_W-1:0]            source_address,
  output logic                         addr_valid,
  output logic                         clear,
  output logic [15:0]                  timestep_id,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef SPIKE_DISPATCH_STATS_EN
  ,
  output logic [31:0]                  dispatched_count,
  output logic [31:0]                  refused_count
`endif
);
  localparam int CNT_W = $clog2(TIMESTEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMESTEP_CYCLES - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] head_dat;
  logic              full;
  logic              empty;
  logic              push_en;
  logic              pop_en;
  logic              repeat_hold;

  assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  assign clear    = (cnt == CNT_LAST);
  assign in_ready = !full && !RESET_Mac;

  // IDLE_ADDR is handshaken but never stored, so it cannot be mistaken for a spike.
  assign push_en = in_valid && in_ready && (in_addr != IDLE_ADDR);

  // An equal head must wait one slot so the MAC sees the address change.
  assign repeat_hold = addr_valid && (head_dat == source_address);
  assign pop_en      = !empty && (cnt_next != CNT_LAST) && !repeat_hold;

  spike_fifo #(
    .W     (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_Mac   (CLK_Mac),
    .RESET_Mac (RESET_Mac),
    .push      (push_en),
    .push_dat  (in_addr),
    .pop       (pop_en),
    .head_dat  (head_dat),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge CLK_Mac) begin
    if (RESET_Mac) begin
      cnt            <= '0;
      timestep_id    <= '0;
      source_address <= IDLE_ADDR;
      addr_valid     <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (clear) timestep_id <= timestep_id + 16'd1;
      if (pop_en) begin
        source_address <= head_dat;
        addr_valid     <= 1'b1;
      end else begin
        source_address <= IDLE_ADDR;
        addr_valid     <= 1'b0;
      end
    end
  end

`ifdef SPIKE_DISPATCH_STATS_EN
  always_ff @(posedge CLK_Mac) begin
    if (RESET_Mac) begin
      dispatched_count <= '0;
      refused_count    <= '0;
    end else begin
      if (addr_valid && (dispatched_count != '1)) dispatched_count <= dispatched_count + 32'd1;
      if (in_valid && !in_ready && (refused_count != '1)) refused_count <= refused_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spike_dispatcher.sv
// tb_spike_dispatcher: queue-based timestep model checked every cycle, plus directed literal traces.
module tb_spike_dispatcher;
  localparam int          DEPTH = 8;
  localparam int          TC    = 4;
  localparam logic [11:0] IDLE  = 12'hFFF;

  logic        CLK_Mac = 1'b0;
  logic        RESET_Mac = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_addr = 12'd0;
  logic        in_ready;
  logic [11:0] source_address;
  logic        addr_valid;
  logic        clear;
  logic [15:0] timestep_id;
  logic [3:0]  fifo_level;
`ifdef SPIKE_DISPATCH_STATS_EN
  logic [31:0] dispatched_count;
  logic [31:0] refused_count;
`endif

  spike_dispatcher dut (
    .CLK_Mac        (CLK_Mac),
    .RESET_Mac      (RESET_Mac),
    .in_valid       (in_valid),
    .in_addr        (in_addr),
    .in_ready       (in_ready),
    .source_address (source_address),
    .addr_valid     (addr_valid),
    .clear          (clear),
    .timestep_id    (timestep_id),
    .fifo_level     (fifo_level)
`ifdef SPIKE_DISPATCH_STATS_EN
    ,
    .dispatched_count (dispatched_count),
    .refused_count    (refused_count)
`endif
  );

  always #5 CLK_Mac = ~CLK_Mac;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the timestep, a spike queue, and what is on the bus.
  int          m_t = 0;
  logic [15:0] m_ts = 16'd0;
  logic [11:0] m_sa = IDLE;
  logic        m_av = 1'b0;
  logic [11:0] m_q[$];
  bit          m_live = 0;
  logic [11:0] seen[$];

  always @(posedge CLK_Mac) begin : model
    int tn;
    bit acc;
    tn  = (m_t + 1) % TC;
    acc = in_valid && (m_q.size() < DEPTH);
    if (RESET_Mac) begin
      m_q.delete();
      m_t    = 0;
      m_ts   = 16'd0;
      m_sa   = IDLE;
      m_av   = 1'b0;
      m_live = 1;
    end else if (m_live) begin
      // Last slot of a timestep is the clear slot; a repeat of the shown address waits a slot.
      if (m_q.size() > 0 && tn != TC - 1 && !(m_av && m_q[0] == m_sa)) begin
        m_sa = m_q.pop_front();
        m_av = 1'b1;
      end else begin
        m_sa = IDLE;
        m_av = 1'b0;
      end
      if (acc && in_addr != IDLE) m_q.push_back(in_addr);
      if (m_t == TC - 1) m_ts = m_ts + 16'd1;
      m_t = tn;
    end
  end

  always @(negedge CLK_Mac) begin
    if (m_live) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!RESET_Mac && m_q.size() < DEPTH)});
      chk("clear", {31'd0, clear}, {31'd0, (m_t == TC - 1)});
      chk("timestep_id", {16'd0, timestep_id}, {16'd0, m_ts});
      chk("source_address", {20'd0, source_address}, {20'd0, m_sa});
      chk("addr_valid", {31'd0, addr_valid}, {31'd0, m_av});
      chk("fifo_level", {28'd0, fifo_level}, 32'(m_q.size()));
      if (addr_valid) seen.push_back(source_address);
    end
  end

  task automatic step();
    @(posedge CLK_Mac);
    #1;
  endtask

  task automatic do_reset();
    RESET_Mac = 1'b1;
    in_valid  = 1'b0;
    step();
    RESET_Mac = 1'b0;
  endtask

  logic [11:0] tr [16];

  task automatic run_trace(input int n, input logic [15:0] vmask, input logic [11:0] a0, input int inc);
    for (int i = 0; i < n; i++) begin
      in_valid = vmask[i];
      in_addr  = a0 + 12'(inc * i);
      @(negedge CLK_Mac);
      tr[i] = source_address;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [11:0] clr_v;
    logic [15:0] ts11;
    int          idle_bad;
    logic [11:0] e3 [12];
    logic [11:0] e5 [10];
    int          a;
    bit          full_seen;
    bit          done;
    bit          acc;
    bit          reached;

    // Idle timesteps: clear every 4th cycle, bus idle throughout.
    do_reset();
    clr_v = '0; idle_bad = 0; ts11 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_Mac);
      clr_v[i] = clear;
      if (source_address !== IDLE || addr_valid !== 1'b0) idle_bad++;
      if (i == 11) ts11 = timestep_id;
      step();
    end
    chk("idle_clear_pattern", {20'd0, clr_v}, 32'h888);
    chk("idle_ts_at_11", {16'd0, ts11}, 32'd2);
    chk("idle_bus", 32'(idle_bad), 32'd0);

    // Single spike pushed at a cnt=0 edge.
    do_reset();
    in_valid = 1'b1; in_addr = 12'd13;
    step();
    in_valid = 1'b0;
    step();
    @(negedge CLK_Mac);
    chk("single_addr", {20'd0, source_address}, 32'd13);
    chk("single_valid", {31'd0, addr_valid}, 32'd1);
    step();
    @(negedge CLK_Mac);
    chk("single_after_addr", {20'd0, source_address}, 32'hFFF);
    chk("single_after_clear", {31'd0, clear}, 32'd1);

    // Burst 13..17: three slots per timestep, clear slot idle, order kept.
    do_reset();
    seen.delete();
    run_trace(12, 16'h001F, 12'd13, 1);
    e3 = '{12'hFFF, 12'hFFF, 12'd13, 12'hFFF, 12'd14, 12'd15,
           12'd16, 12'hFFF, 12'd17, 12'hFFF, 12'hFFF, 12'hFFF};
    for (int i = 0; i < 12; i++) chk($sformatf("burst_cycle%0d", i), {20'd0, tr[i]}, {20'd0, e3[i]});
    chk("burst_count", 32'(seen.size()), 32'd5);

    // Equal back-to-back addresses get an idle slot between them.
    do_reset();
    seen.delete();
    run_trace(10, 16'h0018, 12'd14, 0);
    e5 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
           12'd14, 12'hFFF, 12'hFFF, 12'd14, 12'hFFF};
    for (int i = 0; i < 10; i++) chk($sformatf("repeat_cycle%0d", i), {20'd0, tr[i]}, {20'd0, e5[i]});
    chk("repeat_count", 32'(seen.size()), 32'd2);

    // IDLE_ADDR offered by the router is consumed but never presented.
    do_reset();
    seen.delete();
    in_valid = 1'b1; in_addr = IDLE;
    step();
    in_addr = 12'd21;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("idle_in_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("idle_in_addr", {20'd0, seen[0]}, 32'd21);

    // Fill to full with a held spike; it must enter after the first pop, nothing lost.
    do_reset();
    seen.delete();
    a = 100; full_seen = 0; done = 0;
    in_valid = 1'b1; in_addr = 12'(a);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK_Mac);
      acc = in_ready;
      if (!acc && !full_seen) begin
        full_seen = 1;
        chk("full_level", {28'd0, fifo_level}, 32'd8);
      end
      step();
      if (acc) begin
        if (full_seen) done = 1;
        else begin
          a++;
          in_addr = 12'(a);
        end
      end
    end
    in_valid = 1'b0;
    chk("full_reached", {31'd0, full_seen}, 32'd1);
    chk("held_accepted", {31'd0, done}, 32'd1);
    repeat (60) step();
    chk("full_drain_count", 32'(seen.size()), 32'(a - 99));
    for (int k = 0; k < seen.size(); k++) chk("full_drain_order", {20'd0, seen[k]}, 32'(100 + k));

    // Reset with a backlog queued: everything discarded.
    do_reset();
    in_valid = 1'b1; in_addr = 12'd300;
    reached = 0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge CLK_Mac);
      if (fifo_level >= 4'd6) reached = 1;
      step();
    end
    chk("backlog_reached", {31'd0, reached}, 32'd1);
    RESET_Mac = 1'b1;
    @(negedge CLK_Mac);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    RESET_Mac = 1'b0;
    in_valid  = 1'b0;
    seen.delete();
    @(negedge CLK_Mac);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_clear", {31'd0, clear}, 32'd0);
    chk("rst_ts", {16'd0, timestep_id}, 32'd0);
    chk("rst_valid", {31'd0, addr_valid}, 32'd0);
    repeat (20) step();
    chk("rst_no_leak", 32'(seen.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
